tv80_dma_arbiter: RTL

//  Shares the tv80s 64K memory bus between the CPU and one DMA/loader master.

---
 rtl/tv80_dma_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/tv80_dma_arbiter.sv
// Bus arbiter letting one DMA/loader master borrow the tv80s memory bus via busrq_n/busak_n
// and issue single-byte reads/writes to the negedge-sampled memory array.
module tv80_dma_arbiter #(
   parameter int MAX_BURST   = 16,
   parameter int REQ_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   output logic        cpu_busrq_n,
   input  logic        cpu_busak_n,
   input  logic [15:0] cpu_a,
   input  logic [7:0]  cpu_do,
   input  logic        cpu_mreq_n,
   input  logic        cpu_rd_n,
   input  logic        cpu_wr_n,
   input  logic        dma_req,
   output logic        dma_gnt,
   input  logic        dma_valid,
   input  logic        dma_we,
   input  logic [15:0] dma_addr,
   input  logic [7:0]  dma_wdata,
   output logic        dma_ready,
   output logic [7:0]  dma_rdata,
   output logic        dma_err,
   input  logic [7:0]  mem_di,
   output logic [15:0] mem_a,
   output logic [7:0]  mem_do,
   output logic        mem_mreq_n,
   output logic        mem_rd_n,
   output logic        mem_wr_n,
   output logic [2:0]  dbg_state
);

   // DMA handshake: dma_valid/dma_we/dma_addr/dma_wdata are taken on the posedge where the
   // arbiter is in OWN and dma_valid=1; dma_ready pulses one cycle, two cycles after that sample.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_OWN  = 3'd2,
      S_XFER = 3'd3,
      S_REL  = 3'd4
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic        timeout_hit;
   logic [7:0]  wait_cnt;
   logic [7:0]  burst_cnt;
   logic [15:0] lat_addr;
   logic [7:0]  lat_wdata;
   logic        lat_we;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      timeout_hit = 1'b0;
      case (state)
         S_IDLE: if (dma_req) state_nx = S_REQ;
         S_REQ: begin
            if (!cpu_busak_n)                      state_nx = S_OWN;
            else if (!dma_req)                     state_nx = S_REL;
            else if (wait_cnt == 8'(REQ_TIMEOUT)) begin
               state_nx    = S_IDLE;
               timeout_hit = 1'b1;
            end
         end
         S_OWN: begin
            // The burst limit is checked first so a master streaming dma_valid cannot hog the bus.
            if (burst_cnt == 8'(MAX_BURST)) state_nx = S_REL;
            else if (dma_valid)             state_nx = S_XFER;
            else if (!dma_req)              state_nx = S_REL;
         end
         S_XFER: state_nx = S_OWN;
         S_REL:  if (cpu_busak_n) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt  <= 8'd0;
         burst_cnt <= 8'd0;
         lat_addr  <= 16'h0000;
         lat_wdata <= 8'h00;
         lat_we    <= 1'b0;
         dma_ready <= 1'b0;
         dma_err   <= 1'b0;
         dma_rdata <= 8'h00;
      end else begin
         dma_ready <= (state == S_XFER);
         dma_err   <= timeout_hit;
         // wait_cnt holds the number of cycles spent in REQ, including the current one.
         if (state_nx == S_REQ) wait_cnt <= (state == S_REQ) ? wait_cnt + 8'd1 : 8'd1;
         else                   wait_cnt <= 8'd0;
         if (state == S_XFER)                          burst_cnt <= burst_cnt + 8'd1;
         else if (state == S_REL || state == S_IDLE)   burst_cnt <= 8'd0;
         if (state == S_OWN && state_nx == S_XFER) begin
            lat_addr  <= dma_addr;
            lat_wdata <= dma_wdata;
            lat_we    <= dma_we;
         end
         if (state == S_XFER && !lat_we) dma_rdata <= mem_di;
      end
   end

   always_comb begin
      cpu_busrq_n = !(state == S_REQ || state == S_OWN || state == S_XFER);
      dma_gnt     = (state == S_OWN || state == S_XFER);
      dbg_state   = state;
      if (state == S_IDLE || state == S_REQ) begin
         mem_a      = cpu_a;
         mem_do     = cpu_do;
         mem_mreq_n = cpu_mreq_n;
         mem_rd_n   = cpu_rd_n;
         mem_wr_n   = cpu_wr_n;
      end else begin
         mem_a      = lat_addr;
         mem_do     = lat_wdata;
         mem_mreq_n = (state != S_XFER);
         mem_rd_n   = !(state == S_XFER && !lat_we);
         mem_wr_n   = !(state == S_XFER && lat_we);
      end
   end

endmodule
